result_uart_tx: RTL and testbench

Result-return transmitter for the sparse matrix coprocessor. It accepts one half-precision result and its four status flags through a valid/ready handshake. It packs them into a 3-byte frame and serialises the frame on the UART TxD line as 8N1, LSB first. It is the outbound counterpart of the receive path in `comm`, and it sits between the adder/mult result stage and the board TxD pin.

---
 rtl/comm_pkg.sv | 24 ++
 rtl/uart_tx_byte.sv | 91 +++++++++
 rtl/result_uart_tx.sv | 96 +++++++++
 tb/tb_result_uart_tx.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/comm_pkg.sv
// Shared definitions for the coprocessor UART links.
// Frame layout, header tag and flag positions for the result return path.
package comm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam logic [3:0] HDR_TAG     = 4'hA;
    localparam int         FRAME_BYTES = 3;

    localparam int OVF_BIT  = 3;
    localparam int UNF_BIT  = 2;
    localparam int ZERO_BIT = 1;
    localparam int NAN_BIT  = 0;

    function automatic logic [7:0] hdr_byte(input logic [3:0] flags);
        return {HDR_TAG, flags};
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser, LSB first, with baud counter and framing.
// A start seen in the last stop-bit cycle chains the next byte with no gap.
module uart_tx_byte
    import comm_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       TxD,
    output logic       busy,
    output logic       done
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] LAST = BW'(CLKS_PER_BIT - 1);

    tx_state_t     state;
    logic [BW-1:0] baud;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          tick;

    assign tick = (baud == LAST);
    assign busy = (state != IDLE);
    assign done = (state == STOP) && tick;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            TxD     <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state   <= START;
                        baud    <= '0;
                        bit_idx <= '0;
                        shreg   <= data;
                        TxD     <= 1'b0;
                    end
                end
                START: begin
                    if (tick) begin
                        baud  <= '0;
                        state <= DATA;
                        TxD   <= shreg[0];
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                DATA: begin
                    if (tick) begin
                        baud <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            TxD   <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shreg   <= {1'b0, shreg[7:1]};
                            TxD     <= shreg[1];
                        end
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                STOP: begin
                    if (tick) begin
                        baud <= '0;
                        if (start) begin
                            state   <= START;
                            bit_idx <= '0;
                            shreg   <= data;
                            TxD     <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/result_uart_tx.sv
// Result-return transmitter: latches a half-precision result plus flags
// and sends a 3-byte frame (header, result hi, result lo) over UART.
module result_uart_tx
    import comm_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] result,
    input  logic        overflow,
    input  logic        underflow,
    input  logic        zero,
    input  logic        nan,
    output logic        TxD,
    output logic        TxD_busy,
    output logic        frame_done
);

    localparam logic [1:0] LAST_BYTE = 2'(FRAME_BYTES - 1);

    logic        active;
    logic        start_q;
    logic [1:0]  byte_idx;
    logic [15:0] res_q;
    logic [3:0]  flags_q;
    logic        accept;
    logic        more;
    logic        last;
    logic        start;
    logic [1:0]  sel;
    logic [7:0]  byte_data;
    logic        tx_busy;
    logic        tx_done;

    assign in_ready = !active && !tx_busy;
    assign TxD_busy = !in_ready;
    assign accept   = in_valid && in_ready;
    assign more     = tx_done && (byte_idx != LAST_BYTE);
    assign last     = tx_done && (byte_idx == LAST_BYTE);
    assign start    = start_q || more;
    // the byte loaded on a chained start is the one after the current index
    assign sel      = more ? byte_idx + 2'd1 : byte_idx;

    always_comb begin
        byte_data = res_q[7:0];
        case (sel)
            2'd0:    byte_data = hdr_byte(flags_q);
            2'd1:    byte_data = res_q[15:8];
            default: byte_data = res_q[7:0];
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active     <= 1'b0;
            start_q    <= 1'b0;
            byte_idx   <= '0;
            res_q      <= '0;
            flags_q    <= '0;
            frame_done <= 1'b0;
        end else begin
            start_q    <= accept;
            frame_done <= last;
            if (accept) begin
                active            <= 1'b1;
                byte_idx          <= '0;
                res_q             <= result;
                flags_q[OVF_BIT]  <= overflow;
                flags_q[UNF_BIT]  <= underflow;
                flags_q[ZERO_BIT] <= zero;
                flags_q[NAN_BIT]  <= nan;
            end else if (more) begin
                byte_idx <= byte_idx + 2'd1;
            end
            if (last) begin
                active <= 1'b0;
            end
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .data (byte_data),
        .TxD  (TxD),
        .busy (tx_busy),
        .done (tx_done)
    );

endmodule

// File: tb/tb_result_uart_tx.sv
// Bench for result_uart_tx: waveform-level frame model plus a line decoder.
// Directed frames, held-valid back-to-back, mid-frame reset, random traffic.
module tb_result_uart_tx;

    localparam int C         = 4;
    localparam int FRAME_CYC = 30 * C;

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic        in_valid  = 1'b0;
    logic [15:0] result    = '0;
    logic        overflow  = 1'b0;
    logic        underflow = 1'b0;
    logic        zero      = 1'b0;
    logic        nan       = 1'b0;
    logic        in_ready;
    logic        TxD;
    logic        TxD_busy;
    logic        frame_done;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    result_uart_tx #(.CLKS_PER_BIT(C)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .result    (result),
        .overflow  (overflow),
        .underflow (underflow),
        .zero      (zero),
        .nan       (nan),
        .TxD       (TxD),
        .TxD_busy  (TxD_busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    // Reference model: a frame accepted at edge k puts 30 bits on the line,
    // each C cycles long, starting at edge k+1; ready again at k+1+30C.
    int          k_acc    = -100000;
    int          ready_at = -100000;
    logic [29:0] line_bits = '1;
    logic [7:0]  fb [3];
    logic [7:0]  exp_q [$];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            k_acc    = -100000;
            ready_at = -100000;
            exp_q.delete();
        end else begin
            cyc++;
            if (in_valid && (cyc - 1 >= ready_at)) begin
                fb[0] = {4'hA, overflow, underflow, zero, nan};
                fb[1] = result[15:8];
                fb[2] = result[7:0];
                for (int i = 0; i < 3; i++) begin
                    line_bits[i*10 +: 10] = {1'b1, fb[i], 1'b0};
                    exp_q.push_back(fb[i]);
                end
                k_acc    = cyc;
                ready_at = cyc + FRAME_CYC + 1;
            end
        end
    end

    int   off;
    logic ex_txd;
    logic ex_rdy;
    logic ex_done;

    always @(negedge clk) begin
        off     = cyc - k_acc - 1;
        ex_txd  = (!reset && off >= 0 && off < FRAME_CYC) ?
                  line_bits[off / C] : 1'b1;
        ex_rdy  = reset || (cyc >= ready_at);
        ex_done = !reset && (cyc == ready_at);
        check("outs", {28'd0, TxD, in_ready, TxD_busy, frame_done},
              {28'd0, ex_txd, ex_rdy, !ex_rdy, ex_done});
    end

    // Independent UART receiver sampling mid-bit.
    int         dph = -1;
    logic [7:0] dbyte = '0;
    logic [7:0] want;

    always @(negedge clk) begin
        if (reset) begin
            dph = -1;
        end else if (dph < 0) begin
            if (TxD == 1'b0) dph = 0;
        end else begin
            dph++;
            if (dph % C == C / 2 && dph > C && dph < 9 * C) begin
                dbyte[dph / C - 1] = TxD;
            end else if (dph == 9 * C + C / 2) begin
                check("stop_bit", {31'd0, TxD}, 32'd1);
                check("byte_avail", exp_q.size(), 32'(exp_q.size() > 0 ?
                      exp_q.size() : 1));
                if (exp_q.size() > 0) begin
                    want = exp_q.pop_front();
                    check("byte", {24'd0, dbyte}, {24'd0, want});
                end
                dph = -1;
            end
        end
    end

    task automatic drive_rand();
        result = 16'($urandom);
        {overflow, underflow, zero, nan} = 4'($urandom);
    endtask

    task automatic send(input logic [15:0] r, input logic [3:0] f);
        result   = r;
        {overflow, underflow, zero, nan} = f;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        drive_rand();
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!frame_done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", {31'd0, frame_done}, 32'd1);
        check("done_lat", cyc - k_acc, FRAME_CYC + 1);
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (50) @(negedge clk);

        send(16'h3C00, 4'b0000);
        wait_done(200);
        @(negedge clk);
        send(16'h7C00, 4'b1001);
        wait_done(200);
        @(negedge clk);

        // held valid: second value must wait for the first frame to finish
        result   = 16'h1234;
        {overflow, underflow, zero, nan} = 4'b0101;
        in_valid = 1'b1;
        @(negedge clk);
        result   = 16'hBEEF;
        {overflow, underflow, zero, nan} = 4'b1010;
        wait_done(200);
        @(negedge clk);
        in_valid = 1'b0;
        drive_rand();
        wait_done(200);
        @(negedge clk);

        // reset during bit 3 of byte 1 (bit forced to 0)
        send(16'($urandom) & 16'hF7FF, 4'($urandom));
        while (cyc < k_acc + 58) @(negedge clk);
        check("pre_rst_txd", {31'd0, TxD}, 32'd0);
        #1 reset = 1'b1;
        #1;
        check("rst_txd", {31'd0, TxD}, 32'd1);
        check("rst_flags", {29'd0, in_ready, TxD_busy, frame_done}, 32'd4);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        send(16'($urandom), 4'($urandom));
        wait_done(200);
        @(negedge clk);

        // random traffic, valid toggling also while busy
        for (int i = 0; i < 1500; i++) begin
            in_valid = ($urandom % 4) == 0;
            drive_rand();
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (FRAME_CYC + 10) @(negedge clk);
        check("bytes_left", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
